snake_body_streamer: RTL
========================

Name: snake_body_streamer

Overview:
- Owns the snake segment table: head position, body shift, growth and self-collision.
- Produces the per-move segment stream (x_snake_cur/y_snake_cur with vld_start, vld_t, pixel_done, is_end, length) that apple placement and collision checking consume.
- Closes the loop: takes is_eat back from the apple logic and grows on the next move.
- Sits between the game tick generator and the apple/renderer blocks.

Parameters:
- H_LOGIC_WIDTH, 5, width of logical X coordinate
- V_LOGIC_WIDTH, 5, width of logical Y coordinate
- H_LOGIC_MAX, 5'd31, largest legal X
- V_LOGIC_MAX, 5'd23, largest legal Y
- MAX_LEN, 64, segment table depth; length saturates here
- INIT_X, 5'd0, head X after reset
- INIT_Y, 5'd0, head Y after reset

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- vld  in  1  one-cycle move tick; starts a move when idle
- dir  in  2  requested direction: 0 right, 1 left, 2 up (Y-1), 3 down (Y+1)
- is_eat  in  1  apple-eaten pulse; latched as grow request
- x_snake_cur  out  H_LOGIC_WIDTH  streamed segment X
- y_snake_cur  out  V_LOGIC_WIDTH  streamed segment Y
- vld_start  out  1  pulse: segment 0 (head) on bus
- vld_t  out  1  pulse: segment 1..length-1 on bus
- pixel_done  out  1  high every stream cycle
- is_end  out  1  high from last-segment cycle until next move starts
- length  out  10  current segment count
- busy  out  1  high outside IDLE
- dead  out  1  sticky self-collision flag

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Every output and all state change only on posedge clk.
- Reset values:
  - length = 1; seg[0] = (INIT_X, INIT_Y)
  - cur_dir = right; grow_pending = 0; dead = 0; state = IDLE
  - x/y_snake_cur = (INIT_X, INIT_Y)
  - vld_start, vld_t, pixel_done, is_end, busy = 0
- rst mid-move aborts the move and forces the reset state on the next edge.
- FSM:
  - IDLE
    - vld && !dead -> SHIFT.
    - vld while dead, or vld in any other state, is ignored; vld is not queued.
  - SHIFT
    - On entry: new_len = length+1 if grow_pending && length<MAX_LEN, else length. Clear grow_pending.
    - Index k walks new_len-1 down to 1, one copy seg[k] <= seg[k-1] per cycle: new_len-1 cycles.
    - new_len==1 -> zero cycles, straight to HEAD.
    - length <= new_len on exit.
  - HEAD (1 cycle)
    - Direction: dir is accepted unless it is the exact reverse of cur_dir; a reversal keeps cur_dir.
    - Step seg[0] one cell in cur_dir.
    - Wrap: X H_LOGIC_MAX+1 -> 0, X 0-1 -> H_LOGIC_MAX. Y likewise with V_LOGIC_MAX.
  - STREAM (length cycles, index s = 0..length-1)
    - Drive seg[s]; pixel_done = 1.
    - vld_start = (s==0); vld_t = (s!=0).
    - is_end asserted on s==length-1.
    - For s>=1: seg[s]==seg[0] sets dead.
    - -> IDLE after last.
- is_end stays high in IDLE. It clears on the first SHIFT cycle (or HEAD if no shift).
- busy = (state != IDLE).
- Move latency: vld at cycle T, head on bus at T+1+(new_len-1)+1. For length 1 that is T+2.
- is_eat:
  - Any is_eat pulse sets grow_pending (multiple pulses before a move = one growth).
  - is_eat in the same cycle as SHIFT entry applies to the following move.
- At length==MAX_LEN, growth requests are discarded; length stays MAX_LEN.
- dead clears only on rst.

Optional Feature:
- WALL_KILL_EN
  - Defined: a HEAD step that would leave 0..H_LOGIC_MAX / 0..V_LOGIC_MAX instead sets dead. The head keeps its old position and STREAM still runs once.
  - Undefined: wrap-around as specified above.

Test Plan:
- Reset, vld with dir=0 -> stream 1 cycle: vld_start=1, (1,0), is_end=1, length=1, head on bus at T+2.
- From (0,0), dir=1 (left) on first move -> reversal rejected, head (1,0). Then dir=2 -> (1,23) by wrap.
- is_eat pulse then vld ×2 (dir=0) from (0,0) -> stream 1: length 2, (1,0),(0,0). Stream 2: (2,0),(1,0), length stays 2.
- Grow to length 5 in a line, then dir sequence up, left, down -> dead=1 during STREAM, later vld ignored, busy stays 0.
- vld during SHIFT/STREAM -> ignored, exactly one stream per accepted vld. rst asserted mid-STREAM -> next cycle all outputs at reset values.
- With WALL_KILL_EN: head (31,0), dir=0, vld -> dead=1, head remains (31,0). Without it -> head (0,0), dead=0.

Source files
------------

// File: rtl/snake_body_streamer.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_streamer
// Purpose  : Snake segment table with body shift, growth, head step and a
//            per-move segment stream. Optional macro: WALL_KILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_streamer #(
    parameter int                         H_LOGIC_WIDTH = 5,
    parameter int                         V_LOGIC_WIDTH = 5,
    parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX   = 5'd31,
    parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX   = 5'd23,
    parameter int                         MAX_LEN       = 64,
    parameter logic [H_LOGIC_WIDTH-1:0]   INIT_X        = 5'd0,
    parameter logic [V_LOGIC_WIDTH-1:0]   INIT_Y        = 5'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld,
    input  logic [1:0]                dir,
    input  logic                      is_eat,
    output logic [H_LOGIC_WIDTH-1:0]  x_snake_cur,
    output logic [V_LOGIC_WIDTH-1:0]  y_snake_cur,
    output logic                      vld_start,
    output logic                      vld_t,
    output logic                      pixel_done,
    output logic                      is_end,
    output logic [9:0]                length,
    output logic                      busy,
    output logic                      dead
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] c_DIR_RIGHT = 2'd0;
    localparam logic [1:0] c_DIR_LEFT  = 2'd1;
    localparam logic [1:0] c_DIR_UP    = 2'd2;

    localparam logic [H_LOGIC_WIDTH-1:0] c_X_ONE   = H_LOGIC_WIDTH'(1);
    localparam logic [V_LOGIC_WIDTH-1:0] c_Y_ONE   = V_LOGIC_WIDTH'(1);
    localparam logic [IDX_W-1:0]         c_IDX_ONE = IDX_W'(1);

`ifdef WALL_KILL_EN
    localparam bit c_WALL_KILL = 1'b1;
`else
    localparam bit c_WALL_KILL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_HEAD   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [H_LOGIC_WIDTH-1:0]   r_seg_x [MAX_LEN];
    logic [V_LOGIC_WIDTH-1:0]   r_seg_y [MAX_LEN];
    logic [9:0]                 r_len;
    logic [9:0]                 r_new_len;
    logic [IDX_W-1:0]           r_idx;
    logic [1:0]                 r_dir;
    logic                       r_grow;
    logic                       r_dead;
    logic                       r_ended;

    logic [9:0]                 w_new_len;
    logic                       w_start;
    logic                       w_last;
    logic                       w_hit;
    logic [1:0]                 w_dir;
    logic [H_LOGIC_WIDTH-1:0]   w_head_x;
    logic [V_LOGIC_WIDTH-1:0]   w_head_y;
    logic                       w_off_grid;

    assign w_new_len = (r_grow && (r_len < 10'(MAX_LEN))) ? r_len + 10'd1 : r_len;
    assign w_start   = (r_state == ST_IDLE) && vld && !r_dead;
    assign w_last    = (10'(r_idx) == (r_len - 10'd1));
    // Reversal pairs are 0/1 and 2/3, so the reverse of a direction is dir^1.
    assign w_dir     = (dir == (r_dir ^ 2'd1)) ? r_dir : dir;
    assign w_hit     = (r_state == ST_STREAM) && (r_idx != '0) &&
                       (r_seg_x[r_idx] == r_seg_x[0]) && (r_seg_y[r_idx] == r_seg_y[0]);

    // w_head_* already holds the wrapped position; w_off_grid flags that a wrap happened.
    always_comb begin
        w_head_x   = r_seg_x[0];
        w_head_y   = r_seg_y[0];
        w_off_grid = 1'b0;
        case (w_dir)
            c_DIR_RIGHT: begin
                if (r_seg_x[0] == H_LOGIC_MAX) begin
                    w_head_x   = '0;
                    w_off_grid = 1'b1;
                end else begin
                    w_head_x = r_seg_x[0] + c_X_ONE;
                end
            end
            c_DIR_LEFT: begin
                if (r_seg_x[0] == '0) begin
                    w_head_x   = H_LOGIC_MAX;
                    w_off_grid = 1'b1;
                end else begin
                    w_head_x = r_seg_x[0] - c_X_ONE;
                end
            end
            c_DIR_UP: begin
                if (r_seg_y[0] == '0) begin
                    w_head_y   = V_LOGIC_MAX;
                    w_off_grid = 1'b1;
                end else begin
                    w_head_y = r_seg_y[0] - c_Y_ONE;
                end
            end
            default: begin
                if (r_seg_y[0] == V_LOGIC_MAX) begin
                    w_head_y   = '0;
                    w_off_grid = 1'b1;
                end else begin
                    w_head_y = r_seg_y[0] + c_Y_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_next = (w_new_len == 10'd1) ? ST_HEAD : ST_SHIFT;
            ST_SHIFT:  if (r_idx == c_IDX_ONE) w_state_next = ST_HEAD;
            ST_HEAD:   w_state_next = ST_STREAM;
            default:   if (w_last) w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_x[0] <= INIT_X;
            r_seg_y[0] <= INIT_Y;
            r_len      <= 10'd1;
            r_new_len  <= 10'd1;
            r_idx      <= '0;
            r_dir      <= c_DIR_RIGHT;
            r_grow     <= 1'b0;
            r_dead     <= 1'b0;
            r_ended    <= 1'b0;
        end else begin
            if (is_eat) r_grow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        // An eat in the entry cycle belongs to the next move.
                        r_grow    <= is_eat;
                        r_new_len <= w_new_len;
                        r_idx     <= IDX_W'(w_new_len - 10'd1);
                        r_ended   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_seg_x[r_idx] <= r_seg_x[r_idx - c_IDX_ONE];
                    r_seg_y[r_idx] <= r_seg_y[r_idx - c_IDX_ONE];
                    if (r_idx == c_IDX_ONE) begin
                        r_len <= r_new_len;
                    end else begin
                        r_idx <= r_idx - c_IDX_ONE;
                    end
                end
                ST_HEAD: begin
                    r_dir <= w_dir;
                    r_idx <= '0;
                    if (c_WALL_KILL && w_off_grid) begin
                        r_dead <= 1'b1;
                    end else begin
                        r_seg_x[0] <= w_head_x;
                        r_seg_y[0] <= w_head_y;
                    end
                end
                default: begin
                    if (w_hit) r_dead <= 1'b1;
                    if (w_last) begin
                        r_ended <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
            endcase
        end
    end

    assign x_snake_cur = r_seg_x[r_idx];
    assign y_snake_cur = r_seg_y[r_idx];
    assign vld_start   = (r_state == ST_STREAM) && (r_idx == '0);
    assign vld_t       = (r_state == ST_STREAM) && (r_idx != '0);
    assign pixel_done  = (r_state == ST_STREAM);
    assign is_end      = ((r_state == ST_STREAM) && w_last) || ((r_state == ST_IDLE) && r_ended);
    assign length      = r_len;
    assign busy        = (r_state != ST_IDLE);
    assign dead        = r_dead;

endmodule
`default_nettype wire
